// File: rtl/acc_pkg.sv
// Shared widths, mode encoding and saturation bounds for the window accumulator.
package acc_pkg;

    localparam int IN_W_DEF  = 13;
    localparam int FRAC_DEF  = 4;
    localparam int ACC_W_DEF = 21;
    localparam int DEPTH_DEF = 16;

    typedef enum logic {
        ACC_RUN = 1'b0,
        ACC_WIN = 1'b1
    } acc_mode_e;

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/acc_window_mem.sv
// DEPTH-entry sample ring: write pointer, read-before-write of the slot being
// overwritten, and a saturating fill count that masks stale RAM contents.
module acc_window_mem #(
    parameter int IN_W  = 13,
    parameter int DEPTH = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic            wr_i,
    input  logic [IN_W-1:0] data_i,
    output logic [IN_W-1:0] old_o,
    output logic            full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [IN_W-1:0] ram_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d, waddr;
    logic [CW-1:0]   fill_q, fill_d;
    logic            full_q;

    // A clear that coincides with a write makes that sample slot 0 of a fresh window.
    always_comb begin
        waddr  = clr_i ? '0 : wptr_q;
        wptr_d = wptr_q;
        fill_d = fill_q;
        if (clr_i) begin
            wptr_d = wr_i ? AW'(1) : '0;
            fill_d = wr_i ? CW'(1) : '0;
        end else if (wr_i) begin
            wptr_d = wptr_q + AW'(1);
            fill_d = full_q ? fill_q : fill_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            fill_q <= '0;
            full_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            fill_q <= fill_d;
            full_q <= (fill_d == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_i) ram_q[waddr] <= data_i;
    end

    assign old_o  = full_q ? ram_q[wptr_q] : '0;
    assign full_o = full_q;

endmodule

// File: rtl/window_accumulator.sv
// Signed fixed-point accumulator: saturating running sum (mode 0) or exact
// moving-window sum over the last DEPTH samples (mode 1), plus look-ahead sum.
module window_accumulator
    import acc_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic                    clr,
    input  logic                    mode,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  A,
    output logic signed [ACC_W-1:0] Y,
    output logic signed [ACC_W-1:0] sum_out,
    output logic                    out_valid,
    output logic                    sat,
    output logic                    full
);

    if (ACC_W < IN_W + $clog2(DEPTH)) begin : g_bad_acc_w
        $error("window_accumulator: ACC_W too narrow for IN_W and DEPTH");
    end
    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("window_accumulator: DEPTH must be a power of 2 in 2..256");
    end
    if (FRAC < 0 || FRAC >= IN_W) begin : g_bad_frac
        $error("window_accumulator: FRAC must lie in 0..IN_W-1");
    end

    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(sat_min(ACC_W));

    acc_mode_e               mode_in, mode_q, mode_d;
    logic                    acc, clr_eff, wr_win, ovf;
    logic                    sat_q, sat_d, vld_q, vld_d;
    logic signed [ACC_W-1:0] y_q, y_d, a_ext, old_ext, run_sum, win_sum;
    logic signed [ACC_W:0]   run_wide;
    logic [IN_W-1:0]         old;

    assign mode_in = acc_mode_e'(mode);
    assign acc     = ce & in_valid;
    // A mode switch behaves exactly like clr on the same edge.
    assign clr_eff = ce & (clr | (mode_in != mode_q));
    assign wr_win  = acc & (mode_in == ACC_WIN);
    assign mode_d  = ce ? mode_in : mode_q;

    assign a_ext   = {{(ACC_W-IN_W){A[IN_W-1]}}, A};
    assign old_ext = {{(ACC_W-IN_W){old[IN_W-1]}}, old};

    assign run_wide = {y_q[ACC_W-1], y_q} + {a_ext[ACC_W-1], a_ext};
    assign ovf      = run_wide[ACC_W] ^ run_wide[ACC_W-1];
    assign run_sum  = ovf ? (run_wide[ACC_W] ? Y_MIN : Y_MAX) : run_wide[ACC_W-1:0];
    assign win_sum  = y_q + a_ext - old_ext;

    always_comb begin
        y_d   = y_q;
        sat_d = sat_q;
        vld_d = acc;
        if (clr_eff) begin
            y_d   = acc ? a_ext : '0;
            sat_d = 1'b0;
        end else if (acc) begin
            y_d = (mode_in == ACC_WIN) ? win_sum : run_sum;
            if (mode_in == ACC_RUN && ovf) sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q    <= '0;
            sat_q  <= 1'b0;
            vld_q  <= 1'b0;
            mode_q <= ACC_RUN;
        end else begin
            y_q    <= y_d;
            sat_q  <= sat_d;
            vld_q  <= vld_d;
            mode_q <= mode_d;
        end
    end

    acc_window_mem #(
        .IN_W  (IN_W),
        .DEPTH (DEPTH)
    ) u_win (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (clr_eff),
        .wr_i   (wr_win),
        .data_i (A),
        .old_o  (old),
        .full_o (full)
    );

    assign Y         = y_q;
    assign sum_out   = y_d;
    assign out_valid = vld_q;
    assign sat       = sat_q;

endmodule
